// File: rtl/tdp36k_stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package : tdp36k_fifo_pkg
// Purpose : Shared constants for driving one 18-bit half of an RS_TDP36K
//           block RAM as a stream FIFO: data/address widths, the byte-enable
//           constant, and a helper that places a word index into the RAM's
//           15-bit address field.
// Rev     : 1.0  initial release
// ============================================================================
package tdp36k_fifo_pkg;

   localparam int unsigned      RAM_DATA_W = 18;
   localparam int unsigned      RAM_ADDR_W = 15;
   localparam logic [1:0]       RAM_BE_ALL = 2'b11;

   // The RAM address carries the word index above ADDR_LSB zero bits, so the
   // word index is shifted up into place; bits shifted past the top are lost.
   function automatic logic [RAM_ADDR_W-1:0] word_addr(
      input logic [RAM_ADDR_W-1:0] word_idx,
      input int unsigned           lsb
   );
      return word_idx << lsb;
   endfunction

endpackage : tdp36k_fifo_pkg
`default_nettype wire

// File: rtl/tdp36k_stream_fifo_outstage.sv
`default_nettype none
// ============================================================================
// Module  : tdp36k_fifo_outstage
// Purpose : Two-entry head/skid output buffer that absorbs the block RAM's
//           one-cycle read latency. Returned read data is captured into the
//           head when the head is empty or being popped, otherwise into the
//           skid; a pop promotes the skid into the head.
// Ports   : clk_i, lreset_i (async active-low), flush_i (sync clear)
//           cap_i/cap_data_i : read data returning from the RAM this cycle
//           pop_i            : consumer takes the head this cycle
//           m_valid_o/m_data_o : registered head presentation
//           occ_o            : entries held (0..2)
// Rev     : 1.0  initial release
// ============================================================================
module tdp36k_fifo_outstage
   import tdp36k_fifo_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  lreset_i,
   input  logic                  flush_i,
   input  logic                  cap_i,
   input  logic [RAM_DATA_W-1:0] cap_data_i,
   input  logic                  pop_i,
   output logic                  m_valid_o,
   output logic [RAM_DATA_W-1:0] m_data_o,
   output logic [1:0]            occ_o
);

   logic [RAM_DATA_W-1:0] head_q, head_d;
   logic [RAM_DATA_W-1:0] skid_q, skid_d;
   logic [1:0]            occ_q, occ_d;
   logic                  m_valid_q;

   always_comb begin
      head_d = head_q;
      skid_d = skid_q;
      occ_d  = occ_q;
      if (flush_i) begin
         occ_d = 2'd0;
      end else begin
         if (pop_i) begin
            if (occ_q == 2'd2) begin
               // Skid moves up; a returning word then refills the skid.
               head_d = skid_q;
               if (cap_i) skid_d = cap_data_i;
            end else if (cap_i) begin
               head_d = cap_data_i;
            end
         end else if (cap_i) begin
            if (occ_q == 2'd0) head_d = cap_data_i;
            else               skid_d = cap_data_i;
         end
         occ_d = occ_q + {1'b0, cap_i} - {1'b0, pop_i};
      end
   end

   always_ff @(posedge clk_i or negedge lreset_i) begin
      if (!lreset_i) begin
         head_q    <= '0;
         skid_q    <= '0;
         occ_q     <= 2'd0;
         m_valid_q <= 1'b0;
      end else begin
         head_q    <= head_d;
         skid_q    <= skid_d;
         occ_q     <= occ_d;
         m_valid_q <= (occ_d != 2'd0);
      end
   end

   assign m_valid_o = m_valid_q;
   assign m_data_o  = head_q;
   assign occ_o     = occ_q;

endmodule : tdp36k_fifo_outstage
`default_nettype wire

// File: rtl/tdp36k_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tdp36k_stream_fifo
// Purpose : First-word-fall-through valid/ready FIFO built on one 18-bit half
//           of an RS_TDP36K block RAM. Port A1 writes, port B1 prefetches into
//           a 2-entry output stage so both streams can run at 1 word/cycle.
// Ports   : clk_i, lreset_i (async active-low), flush_i (sync clear)
//           s_data_i/s_valid_i/s_ready_o : write stream
//           m_data_o/m_valid_o/m_ready_i : read stream
//           count_o, almost_full_o, almost_empty_o : registered fill status
//           bram_wen_o/waddr_o/wdata_o/be_o -> A1, bram_ren_o/raddr_o -> B1,
//           bram_rdata_i <- RDATA_B1, bram_flush_o -> FLUSH1
// Rev     : 1.0  initial release
// ============================================================================
module tdp36k_stream_fifo
   import tdp36k_fifo_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned ADDR_LSB   = 5,   // DEPTH_LOG2 + ADDR_LSB == 15
   parameter int unsigned AFULL_TH   = 1020,
   parameter int unsigned AEMPTY_TH  = 2
) (
   input  logic                    clk_i,
   input  logic                    lreset_i,
   input  logic                    flush_i,
   input  logic [RAM_DATA_W-1:0]   s_data_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   output logic [RAM_DATA_W-1:0]   m_data_o,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic [DEPTH_LOG2+1:0]   count_o,
   output logic                    almost_full_o,
   output logic                    almost_empty_o,
   output logic                    bram_wen_o,
   output logic [RAM_ADDR_W-1:0]   bram_waddr_o,
   output logic [RAM_DATA_W-1:0]   bram_wdata_o,
   output logic [1:0]              bram_be_o,
   output logic                    bram_ren_o,
   output logic [RAM_ADDR_W-1:0]   bram_raddr_o,
   input  logic [RAM_DATA_W-1:0]   bram_rdata_i,
   output logic                    bram_flush_o
);

   localparam int unsigned             CNT_W    = DEPTH_LOG2 + 2;
   localparam logic [DEPTH_LOG2:0]     MEM_CAP  = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2-1:0]   PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]        AFULL_C  = AFULL_TH[CNT_W-1:0];
   localparam logic [CNT_W-1:0]        AEMPTY_C = AEMPTY_TH[CNT_W-1:0];

   logic                  rst_done_q;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   mem_words_q, mem_words_d;
   logic                  inflight_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  afull_q, aempty_q, bram_flush_q;

   logic                  w_s_ready, w_push, w_pop, w_ren;
   logic [1:0]            w_occ;
   logic [2:0]            w_pending;

   // Writes stay blocked until the first clock after reset has been seen.
   assign w_s_ready = rst_done_q & (mem_words_q < MEM_CAP);
   assign w_push    = s_valid_i & w_s_ready & ~flush_i;
   assign w_pop     = m_valid_o & m_ready_i & ~flush_i;

   // Words the output stage will hold after this cycle's pop, counting the one
   // already on its way back from the RAM. Prefetch only if a slot stays free.
   assign w_pending = {1'b0, w_occ} + {2'b00, inflight_q} - {2'b00, w_pop};
   assign w_ren     = rst_done_q & ~flush_i & (mem_words_q != '0) & (w_pending < 3'd2);

   assign mem_words_d = mem_words_q + {{DEPTH_LOG2{1'b0}}, w_push}
                                    - {{DEPTH_LOG2{1'b0}}, w_ren};

   // A word moving RAM -> in flight -> stage is conserved, so the total only
   // changes on stream handshakes.
   assign count_d = flush_i ? '0
                  : count_q + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop};

   always_ff @(posedge clk_i or negedge lreset_i) begin
      if (!lreset_i) begin
         rst_done_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         mem_words_q  <= '0;
         inflight_q   <= 1'b0;
         count_q      <= '0;
         afull_q      <= 1'b0;
         aempty_q     <= 1'b1;
         bram_flush_q <= 1'b0;
      end else begin
         rst_done_q   <= 1'b1;
         bram_flush_q <= flush_i;
         count_q      <= count_d;
         afull_q      <= (count_d >= AFULL_C);
         aempty_q     <= (count_d <= AEMPTY_C);
         if (flush_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_words_q <= '0;
            inflight_q  <= 1'b0;
         end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (w_ren)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            mem_words_q <= mem_words_d;
            inflight_q  <= w_ren;
         end
      end
   end

   tdp36k_fifo_outstage u_outstage (
      .clk_i      (clk_i),
      .lreset_i   (lreset_i),
      .flush_i    (flush_i),
      .cap_i      (inflight_q),
      .cap_data_i (bram_rdata_i),
      .pop_i      (w_pop),
      .m_valid_o  (m_valid_o),
      .m_data_o   (m_data_o),
      .occ_o      (w_occ)
   );

   assign s_ready_o      = w_s_ready;
   assign count_o        = count_q;
   assign almost_full_o  = afull_q;
   assign almost_empty_o = aempty_q;

   assign bram_wen_o     = w_push;
   assign bram_waddr_o   = word_addr(RAM_ADDR_W'(wr_ptr_q), ADDR_LSB);
   assign bram_wdata_o   = s_data_i;
   assign bram_be_o      = RAM_BE_ALL;
   assign bram_ren_o     = w_ren;
   assign bram_raddr_o   = word_addr(RAM_ADDR_W'(rd_ptr_q), ADDR_LSB);
   assign bram_flush_o   = bram_flush_q;

endmodule : tdp36k_stream_fifo
`default_nettype wire

// File: doc/tdp36k_stream_fifo.md
# tdp36k_stream_fifo

Synchronous first-word-fall-through FIFO controller that turns one 18-bit half of an RS_TDP36K block RAM into a valid/ready stream buffer. Sits directly upstream of the RAM primitive: it generates write/read enables, addresses, byte enables and flush for the A1 (write) and B1 (read) ports, absorbs the RAM's 1-cycle read latency with a 2-entry output stage, and presents full-throughput streams on both sides.

## Interface
- DEPTH_LOG2, 10, log2 of RAM words used (1024 x 18)
- ADDR_LSB, 5, bit position of word address inside the 15-bit RAM address; DEPTH_LOG2+ADDR_LSB must equal 15
- AFULL_TH, 1020, almost_full asserts when count >= AFULL_TH
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH

- clk  in  1  single clock for stream and RAM ports
- lreset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all contents
- s_data  in  18  write-side data; s_valid  in  1; s_ready  out  1
- m_data  out  18  read-side data; m_valid  out  1; m_ready  in  1
- count  out  DEPTH_LOG2+2  words held (RAM + in flight + output stage)
- almost_full, almost_empty  out  1 each
- bram_wen  out  1  -> WEN_A1; bram_waddr  out  15  -> ADDR_A1; bram_wdata  out  18  -> WDATA_A1; bram_be  out  2  -> BE_A1, constant 2'b11
- bram_ren  out  1  -> REN_B1; bram_raddr  out  15  -> ADDR_B1; bram_rdata  in  18  <- RDATA_B1
- bram_flush  out  1  -> FLUSH1

## Operation
- Reset (lreset low, async): wr_ptr, rd_ptr, mem_words, occupancy, count = 0; m_valid 0, m_data 0; s_ready 0; bram_wen/ren/flush 0; addresses 0; almost_full 0, almost_empty 1. s_ready rises on first clk edge after lreset releases.
- Write: push = s_valid & s_ready. Drives bram_wen=push, bram_waddr={wr_ptr, ADDR_LSB zeros}, bram_wdata=s_data combinationally; wr_ptr increments mod 2^DEPTH_LOG2 (wraps 1023->0).
- s_ready = rst_done & (mem_words < 2^DEPTH_LOG2).
- Prefetch: pop = m_valid & m_ready. bram_ren asserts when mem_words > 0 and (occ + inflight - pop) < 2; bram_raddr={rd_ptr, zeros}; rd_ptr increments, inflight flop set for next cycle.
- Output stage: head + skid registers, occ 0..2. Returned bram_rdata (cycle after ren) enters head if head empty or being popped, else skid. Pop moves skid to head.
- mem_words: +push, -bram_ren, registered; a word written in cycle t is readable no earlier than t+1 (no same-address same-cycle RAM access).
- count = mem_words + inflight + occ; max 2^DEPTH_LOG2 + 2.
- flush: next edge clears pointers, mem_words, occ, inflight, m_valid; in-flight rdata discarded; bram_flush pulses 1 cycle; push/pop in the flush cycle are ignored; s_ready stays 1.
- Simultaneous push and pop at any level: count unchanged; at mem full, push blocked even if pop.

## Timing
- Write-to-m_valid latency from empty: push at cycle t, ren t+1, rdata t+2, m_valid 1 at t+3 (registered).
- Sustained 1 word/cycle in and out once occ=2.
- almost_full/almost_empty registered from next-state count; same cycle as count.
- Reset mid-transfer: all state lost immediately, no RAM access until s_ready returns.

## Structure
- Package tdp36k_fifo_pkg: RAM data width 18, address width 15, BE constant 2'b11, localparam helper for word-address packing.
- One sub-module natural: tdp36k_fifo_outstage (2-entry head/skid buffer with occ counter, rdata capture, pop).

## Test plan
- Reset release, push 0x00001..0x00005, m_ready=1 -> m_data 1..5 in order, first m_valid 3 cycles after first push, count returns 0.
- Fill with m_ready=0: 1026 pushes accepted (1024 RAM + 2 stage), s_ready low on 1027th, almost_full at count 1020, bram_waddr wrapped 0x7FE0->0x0000.
- Continuous stream both sides for 5000 words with random data -> zero loss, one word/cycle after fill, count stable.
- Random s_valid/m_ready (50%) for 10000 words -> output matches scoreboard, count never exceeds 1026.
- flush with count=300 and a read in flight -> next cycle count 0, m_valid 0, bram_flush 1-cycle pulse, next pushed 0x2A emerges first.
- lreset asserted mid-stream (count=17) -> all outputs to reset values asynchronously, no bram_wen/ren until s_ready returns.
